// File: rtl/dpll_loop_ctrl.sv
// dpll_loop_ctrl
//   Digital PLL loop controller: PI loop filter driven by PFD up/down pulses,
//   programmable feedback divider and a lock/holdover state machine.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ACQUIRE  | loop running, waiting for LOCK_CNT consecutive quiet cycles
//   LOCKED   | lock declared; UNLOCK_CNT consecutive error cycles drop it
//   HOLDOVER | freeze asserted; integrator and control word held
//
// Ports
//   clk     in   single clock, posedge
//   rst     in   asynchronous active-high reset
//   up      in   PFD up pulse
//   down    in   PFD down pulse
//   div_n   in   requested feedback divide ratio (latched at period wrap)
//   freeze  in   holdover request
//   clk_fb  out  divided feedback clock (registered)
//   ctrl    out  signed DCO control word (registered)
//   sat     out  ctrl or integrator clamped in this update
//   locked  out  lock indicator (registered)
//   state   out  FSM state: 0 ACQUIRE, 1 LOCKED, 2 HOLDOVER
module dpll_loop_ctrl #(
  parameter int CTRL_W      = 16,
  parameter int DIV_W       = 8,
  parameter int KP          = 4,
  parameter int KI          = 1,
  parameter int LOCK_CNT    = 32,
  parameter int UNLOCK_CNT  = 4,
  parameter int DIV_DEFAULT = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     up,
  input  logic                     down,
  input  logic [DIV_W-1:0]         div_n,
  input  logic                     freeze,
  output logic                     clk_fb,
  output logic signed [CTRL_W-1:0] ctrl,
  output logic                     sat,
  output logic                     locked,
  output logic [1:0]               state
);

  typedef enum logic [1:0] {
    ACQUIRE  = 2'd0,
    LOCKED   = 2'd1,
    HOLDOVER = 2'd2
  } state_t;

  // Wide enough that integ + gain*e can never wrap before the clamp.
  localparam int WW = CTRL_W + DIV_W + 2;
  localparam logic signed [WW-1:0] MAX_W = {{(WW-CTRL_W+1){1'b0}}, {(CTRL_W-1){1'b1}}};
  localparam logic signed [WW-1:0] MIN_W = {{(WW-CTRL_W+1){1'b1}}, {(CTRL_W-1){1'b0}}};
  localparam logic signed [WW-1:0] KP_W  = WW'(KP);
  localparam logic signed [WW-1:0] KI_W  = WW'(KI);

  localparam logic [DIV_W-1:0] DIV_INIT = (DIV_DEFAULT < 2) ? DIV_W'(2) : DIV_W'(DIV_DEFAULT);

  localparam int QW = (LOCK_CNT   < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int UW = (UNLOCK_CNT < 1) ? 1 : $clog2(UNLOCK_CNT + 1);
  localparam logic [QW-1:0] LOCK_Q   = QW'(LOCK_CNT);
  localparam logic [UW-1:0] UNLOCK_E = UW'(UNLOCK_CNT);

  // Returns {clamped, value}.
  function automatic logic [CTRL_W:0] clamp_w(input logic signed [WW-1:0] v);
    if (v > MAX_W)
      clamp_w = {1'b1, MAX_W[CTRL_W-1:0]};
    else if (v < MIN_W)
      clamp_w = {1'b1, MIN_W[CTRL_W-1:0]};
    else
      clamp_w = {1'b0, v[CTRL_W-1:0]};
  endfunction

  // ---------------- loop filter ----------------
  logic signed [CTRL_W-1:0] integ;
  logic signed [WW-1:0]     e_w, integ_w, isum_w, inxt_w, csum_w;
  logic [CTRL_W:0]          iclamp, cclamp;
  logic                     quiet;

  assign quiet = (up == down);

  always_comb begin
    e_w = '0;
    if (up && !down)
      e_w = {{(WW-1){1'b0}}, 1'b1};
    else if (down && !up)
      e_w = '1;
    integ_w = {{(WW-CTRL_W){integ[CTRL_W-1]}}, integ};
    isum_w  = integ_w + KI_W * e_w;
    iclamp  = clamp_w(isum_w);
    inxt_w  = {{(WW-CTRL_W){iclamp[CTRL_W-1]}}, iclamp[CTRL_W-1:0]};
    csum_w  = inxt_w + KP_W * e_w;
    cclamp  = clamp_w(csum_w);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ <= '0;
      ctrl  <= '0;
      sat   <= 1'b0;
    end else if (freeze) begin
      ctrl  <= integ;
      sat   <= 1'b0;
    end else begin
      integ <= iclamp[CTRL_W-1:0];
      ctrl  <= cclamp[CTRL_W-1:0];
      sat   <= iclamp[CTRL_W] | cclamp[CTRL_W];
    end
  end

  // ---------------- feedback divider ----------------
  // A new ratio is only taken at the wrap so every period is whole.
  logic [DIV_W-1:0] n_q, cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q    <= DIV_INIT;
      cnt_q  <= '0;
      clk_fb <= 1'b0;
    end else begin
      clk_fb <= (cnt_q < (n_q >> 1));
      if (cnt_q == n_q - DIV_W'(1)) begin
        cnt_q <= '0;
        n_q   <= (div_n < DIV_W'(2)) ? DIV_W'(2) : div_n;
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

  // ---------------- lock FSM ----------------
  state_t        state_q, state_nxt;
  logic [QW-1:0] q_cnt, q_nxt;
  logic [UW-1:0] e_cnt, e_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACQUIRE;
      q_cnt   <= '0;
      e_cnt   <= '0;
      locked  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      q_cnt   <= q_nxt;
      e_cnt   <= e_nxt;
      locked  <= (state_nxt == LOCKED);
    end
  end

  always_comb begin
    state_nxt = state_q;
    q_nxt     = q_cnt;
    e_nxt     = e_cnt;
    if (quiet) begin
      q_nxt = (q_cnt == LOCK_Q) ? q_cnt : q_cnt + QW'(1);
      e_nxt = '0;
    end else begin
      q_nxt = '0;
      e_nxt = (e_cnt == UNLOCK_E) ? e_cnt : e_cnt + UW'(1);
    end
    case (state_q)
      ACQUIRE:  if (q_nxt == LOCK_Q)   state_nxt = LOCKED;
      LOCKED:   if (e_nxt == UNLOCK_E) state_nxt = ACQUIRE;
      HOLDOVER: if (!freeze) begin
                  // Relock must be earned from scratch after holdover.
                  state_nxt = ACQUIRE;
                  q_nxt     = '0;
                  e_nxt     = '0;
                end
      default:  state_nxt = ACQUIRE;
    endcase
    if (freeze)
      state_nxt = HOLDOVER;
  end

  assign state = state_q;

endmodule

// File: tb/tb_dpll_loop_ctrl.sv
module tb_dpll_loop_ctrl;

  logic              clk = 1'b0;
  logic              rst, up, down, freeze;
  logic [7:0]        div_n;
  logic              clk_fb16, sat16, locked16;
  logic signed [15:0] ctrl16;
  logic [1:0]        state16;
  logic              clk_fb8, sat8, locked8;
  logic signed [7:0] ctrl8;
  logic [1:0]        state8;

  always #5 clk = ~clk;

  dpll_loop_ctrl dut16 (
    .clk(clk), .rst(rst), .up(up), .down(down), .div_n(div_n), .freeze(freeze),
    .clk_fb(clk_fb16), .ctrl(ctrl16), .sat(sat16), .locked(locked16), .state(state16)
  );

  dpll_loop_ctrl #(.CTRL_W(8)) dut8 (
    .clk(clk), .rst(rst), .up(up), .down(down), .div_n(div_n), .freeze(freeze),
    .clk_fb(clk_fb8), .ctrl(ctrl8), .sat(sat8), .locked(locked8), .state(state8)
  );

  int n_vec = 0;
  int n_err = 0;

  // reference model (index 0: 16-bit instance, 1: 8-bit instance)
  longint m_integ [2];
  longint m_ctrl  [2];
  int     m_sat   [2];
  int     wid     [2] = '{16, 8};
  int     m_quiet, m_errc, m_state, m_n, m_cnt, m_clk_fb;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clip(input longint v, input int w, output longint r, output int hit);
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    hit = 0;
    r = v;
    if (v > hi) begin r = hi; hit = 1; end
    if (v < lo) begin r = lo; hit = 1; end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_integ[k] = 0; m_ctrl[k] = 0; m_sat[k] = 0;
    end
    m_quiet = 0; m_errc = 0; m_state = 0;
    m_n = 10; m_cnt = 0; m_clk_fb = 0;
  endtask

  task automatic model_step();
    int e, h1, h2;
    longint ni, nc;
    e = (up && !down) ? 1 : ((down && !up) ? -1 : 0);
    for (int k = 0; k < 2; k++) begin
      if (freeze) begin
        m_ctrl[k] = m_integ[k];
        m_sat[k]  = 0;
      end else begin
        clip(m_integ[k] + 1 * e, wid[k], ni, h1);
        clip(ni + 4 * e, wid[k], nc, h2);
        m_integ[k] = ni;
        m_ctrl[k]  = nc;
        m_sat[k]   = h1 | h2;
      end
    end
    if (m_state == 2 && !freeze) begin
      m_state = 0; m_quiet = 0; m_errc = 0;
    end else begin
      if (e == 0) begin
        m_quiet = (m_quiet < 32) ? m_quiet + 1 : 32;
        m_errc  = 0;
      end else begin
        m_errc  = (m_errc < 4) ? m_errc + 1 : 4;
        m_quiet = 0;
      end
      if (freeze)                           m_state = 2;
      else if (m_state == 0 && m_quiet == 32) m_state = 1;
      else if (m_state == 1 && m_errc == 4)   m_state = 0;
    end
    m_clk_fb = (m_cnt < m_n / 2) ? 1 : 0;
    if (m_cnt == m_n - 1) begin
      m_cnt = 0;
      m_n   = (div_n < 2) ? 2 : int'(div_n);
    end else begin
      m_cnt++;
    end
  endtask

  task automatic compare_all();
    chk("ctrl16",   ctrl16,   m_ctrl[0]);
    chk("sat16",    sat16,    m_sat[0]);
    chk("ctrl8",    ctrl8,    m_ctrl[1]);
    chk("sat8",     sat8,     m_sat[1]);
    chk("clk_fb16", clk_fb16, m_clk_fb);
    chk("clk_fb8",  clk_fb8,  m_clk_fb);
    chk("state16",  state16,  m_state);
    chk("state8",   state8,   m_state);
    chk("locked16", locked16, (m_state == 1) ? 1 : 0);
    chk("locked8",  locked8,  (m_state == 1) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // Called 1 time unit after a rising edge; pulse stays clear of the edges.
  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    model_reset();
    compare_all();
    #2;
    rst = 1'b0;
  endtask

  task automatic quiet_cycles(input int n);
    up = 1'b0; down = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; up = 1'b0; down = 1'b0; freeze = 1'b0; div_n = 8'd10;
    #2;
    model_reset();
    compare_all();
    chk("rst_ctrl", ctrl16, 0);
    chk("rst_state", state16, 0);
    #10;
    rst = 1'b0;

    // quiet from reset: locked exactly on the 32nd edge, ctrl stays 0
    quiet_cycles(31);
    chk("lock31_locked", locked16, 0);
    chk("lock31_ctrl", ctrl16, 0);
    quiet_cycles(1);
    chk("lock32_locked", locked16, 1);
    chk("lock32_state", state16, 1);
    chk("lock32_ctrl", ctrl16, 0);

    // single up pulse: ctrl = KI + KP = 5, then integ = 1
    pulse_reset();
    up = 1'b1;
    cycle();
    chk("pulse_ctrl5", ctrl16, 5);
    chk("pulse_sat", sat16, 0);
    up = 1'b0;
    cycle();
    chk("pulse_ctrl1", ctrl16, 1);
    chk("pulse_sat2", sat16, 0);

    // saturation on the 8-bit instance, both rails
    pulse_reset();
    up = 1'b1;
    for (int i = 0; i < 140; i++) cycle();
    chk("sat_hi_ctrl8", ctrl8, 127);
    chk("sat_hi_sat8", sat8, 1);
    up = 1'b0; down = 1'b1;
    for (int i = 0; i < 300; i++) cycle();
    chk("sat_lo_ctrl8", ctrl8, -128);
    chk("sat_lo_sat8", sat8, 1);
    down = 1'b0;

    // unlock needs 4 consecutive error cycles
    pulse_reset();
    quiet_cycles(32);
    chk("ul_locked0", locked16, 1);
    down = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("ul_burst3", locked16, 1);
    quiet_cycles(1);
    down = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    chk("ul_burst4_pre", locked16, 1);
    cycle();
    chk("ul_burst4_locked", locked16, 0);
    chk("ul_burst4_state", state16, 0);
    down = 1'b0;

    // divider: 10, change to 4 mid-period, then 1 (treated as 2)
    pulse_reset();
    div_n = 8'd10;
    for (int i = 0; i < 13; i++) cycle();
    div_n = 8'd4;
    for (int i = 0; i < 24; i++) cycle();
    div_n = 8'd1;
    for (int i = 0; i < 12; i++) cycle();
    div_n = 8'd0;
    for (int i = 0; i < 6; i++) cycle();
    div_n = 8'd10;

    // holdover: ctrl frozen at integ = 3, relock takes 32 fresh quiet cycles
    pulse_reset();
    up = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    quiet_cycles(32);
    chk("ho_locked", locked16, 1);
    chk("ho_ctrl_pre", ctrl16, 3);
    freeze = 1'b1;
    for (int i = 0; i < 10; i++) begin
      up = ($urandom_range(0, 1) == 1);
      cycle();
      chk("ho_state", state16, 2);
      chk("ho_locked_low", locked16, 0);
      chk("ho_ctrl_held", ctrl16, 3);
    end
    up = 1'b0;
    freeze = 1'b0;
    cycle();
    chk("ho_release_state", state16, 0);
    quiet_cycles(31);
    chk("ho_relock31", locked16, 0);
    quiet_cycles(1);
    chk("ho_relock32", locked16, 1);

    // randomized traffic with varying error density, freeze and resets
    begin
      int dens;
      dens = 8;
      for (int i = 0; i < 4000; i++) begin
        if (i % 250 == 0) dens = $urandom_range(2, 60);
        up   = ($urandom_range(0, dens - 1) == 0);
        down = ($urandom_range(0, dens - 1) == 0);
        if ($urandom_range(0, 3) == 0 && i % 300 > 200) begin
          up = 1'b1; down = 1'b0;
        end
        if ($urandom_range(0, 40) == 0) freeze = ~freeze;
        if ($urandom_range(0, 30) == 0) div_n = 8'($urandom_range(0, 20));
        cycle();
        if ($urandom_range(0, 400) == 0) pulse_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
